// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared offsets and byte-strobe helper for the multi-hart CLINT
package clint_pkg;

  localparam logic [63:0] MSIP_OFF     = 64'h0000;
  localparam logic [63:0] MTIMECMP_OFF = 64'h4000;
  localparam logic [63:0] MTIME_OFF    = 64'hBFF8;
  localparam int          MAX_HART     = 8;

  // Merge the strobed bytes of wdata into old; unstrobed bytes keep old
  function automatic logic [63:0] apply_strb(input logic [63:0] old,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// rtl/clint_prescaler.sv - divides enabled core cycles down to mtime ticks
module clint_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_en_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = tick_en_i && (cnt_q == LAST);

  // Count enabled cycles, wrapping on the cycle that emits a tick; hold when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (tick_en_i) cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_multihart.sv
// rtl/clint_multihart.sv - core-local interruptor: shared mtime, per-hart mtimecmp and msip
module clint_multihart
  import clint_pkg::*;
#(
  parameter int          NHART        = 2,
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] BASE         = 64'h0200_0000,
  parameter logic [63:0] MTIMECMP_RST = 64'd1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             req_valid,
  input  logic             req_wen,
  input  logic [63:0]      req_addr,
  input  logic [63:0]      req_wdata,
  input  logic [7:0]       req_wstrb,
  output logic             resp_valid,
  output logic [63:0]      resp_rdata,
  output logic             resp_err,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip,
  output logic [63:0]      mtime_o
);

  localparam int          HW        = $clog2(MAX_HART);
  localparam logic [63:0] MSIP_SPAN = 64'(4 * NHART);
  localparam logic [63:0] CMP_SPAN  = 64'(8 * NHART);

  logic          tick;
  logic [63:0]   lane;
  logic          sel_msip, sel_cmp, sel_mtime, mapped;
  logic          wr_en, rd_en;
  logic [HW-1:0] msip_hart, cmp_hart;
  logic [63:0]   rd_data;

  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      cmp_q [NHART];
  logic [63:0]      cmp_d [NHART];
  logic [NHART-1:0] msip_q, msip_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [63:0]      resp_rdata_q, resp_rdata_d;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock     (clock),
    .reset     (reset),
    .tick_en_i (tick_en),
    .tick_o    (tick)
  );

  // Decode the request on its 8-byte lane; offsets below BASE wrap high and fall out of every window
  always_comb begin
    lane      = (req_addr - BASE) & ~64'h7;
    sel_msip  = (lane - MSIP_OFF) < MSIP_SPAN;
    sel_cmp   = (lane - MTIMECMP_OFF) < CMP_SPAN;
    sel_mtime = (lane == MTIME_OFF);
    mapped    = sel_msip || sel_cmp || sel_mtime;
    msip_hart = lane[2 +: HW];
    cmp_hart  = lane[3 +: HW];
    wr_en     = req_valid && req_wen && mapped;
    rd_en     = req_valid && !req_wen && mapped;
  end

  // Read mux; an msip lane carries the even hart in bit 0 and the odd hart in bit 32
  always_comb begin
    rd_data = '0;
    if (sel_msip) begin
      for (int h = 0; h < NHART; h++) begin
        if (msip_hart == HW'(h - h % 2)) rd_data[32*(h%2)] = msip_q[h];
      end
    end else if (sel_cmp) begin
      for (int h = 0; h < NHART; h++) begin
        if (cmp_hart == HW'(h)) rd_data = cmp_q[h];
      end
    end else if (sel_mtime) begin
      rd_data = mtime_q;
    end
  end

  // Next state: strobed mtime bytes override the ticked value, unwritten bytes keep the increment
  always_comb begin
    mtime_d = mtime_q + 64'(tick);
    if (wr_en && sel_mtime) mtime_d = apply_strb(mtime_d, req_wdata, req_wstrb);

    msip_d = msip_q;
    for (int h = 0; h < NHART; h++) begin
      if (wr_en && sel_msip && (msip_hart == HW'(h - h % 2)) && req_wstrb[4*(h%2)])
        msip_d[h] = req_wdata[32*(h%2)];
    end

    for (int h = 0; h < NHART; h++) begin
      cmp_d[h] = cmp_q[h];
      if (wr_en && sel_cmp && (cmp_hart == HW'(h)))
        cmp_d[h] = apply_strb(cmp_q[h], req_wdata, req_wstrb);
    end

    resp_valid_d = req_valid;
    resp_err_d   = req_valid && !mapped;
    resp_rdata_d = rd_en ? rd_data : '0;
  end

  // State registers; reset also drops any response in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q      <= '0;
      msip_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      for (int h = 0; h < NHART; h++) cmp_q[h] <= MTIMECMP_RST;
    end else begin
      mtime_q      <= mtime_d;
      msip_q       <= msip_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      for (int h = 0; h < NHART; h++) cmp_q[h] <= cmp_d[h];
    end
  end

  // Timer interrupt per hart: unsigned compare of the live registers
  always_comb begin
    mtip = '0;
    for (int h = 0; h < NHART; h++) mtip[h] = (mtime_q >= cmp_q[h]);
  end

  assign msip       = msip_q;
  assign mtime_o    = mtime_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_clint_multihart.sv
// tb/tb_clint_multihart.sv - self-checking bench for clint_multihart
module tb_clint_multihart;

  localparam int          NH   = 2;
  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] CRST = 64'd1000000;

  logic          clock, reset, tick_en, req_valid, req_wen;
  logic [63:0]   req_addr, req_wdata;
  logic [7:0]    req_wstrb;
  logic          resp_valid, resp_err, q_resp_valid, q_resp_err;
  logic [63:0]   resp_rdata, q_resp_rdata, mtime_o, q_mtime_o;
  logic [NH-1:0] mtip, msip, q_mtip, q_msip;

  clint_multihart #(.NHART(NH), .TICK_DIV(1), .BASE(BASE), .MTIMECMP_RST(CRST)) u_dut (
    .clock(clock), .reset(reset), .tick_en(tick_en), .req_valid(req_valid), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mtip(mtip), .msip(msip), .mtime_o(mtime_o));

  clint_multihart #(.NHART(NH), .TICK_DIV(4), .BASE(BASE), .MTIMECMP_RST(CRST)) u_dut4 (
    .clock(clock), .reset(reset), .tick_en(tick_en), .req_valid(req_valid), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(q_resp_valid), .resp_rdata(q_resp_rdata), .resp_err(q_resp_err),
    .mtip(q_mtip), .msip(q_msip), .mtime_o(q_mtime_o));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of the register file
  logic [63:0] m_mtime, m_mtime4, m_rd;
  logic [63:0] m_cmp [NH];
  logic        m_msip [NH];
  logic        m_rv, m_re;
  int          m_ph4;

  function automatic logic lane_mapped(input logic [63:0] l);
    return (l < 64'(4*NH)) || (l >= 64'h4000 && l < 64'h4000 + 64'(8*NH)) || (l == 64'hBFF8);
  endfunction

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    int i;
    if (a < 64'(4*NH)) begin
      i = int'(a);
      return (i % 4 == 0) ? {7'b0, m_msip[i/4]} : 8'h00;
    end else if (a >= 64'h4000 && a < 64'h4000 + 64'(8*NH)) begin
      i = int'(a - 64'h4000);
      return m_cmp[i/8][8*(i%8) +: 8];
    end else if (a >= 64'hBFF8 && a < 64'hC000) begin
      i = int'(a - 64'hBFF8);
      return m_mtime[8*i +: 8];
    end
    return 8'h00;
  endfunction

  task automatic model_edge();
    logic [63:0] l, nm1, nm4, rd, a;
    logic [7:0]  by;
    logic        mp;
    int          i;
    if (reset) begin
      m_mtime = '0; m_mtime4 = '0; m_ph4 = 0;
      m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
      for (int h = 0; h < NH; h++) begin m_cmp[h] = CRST; m_msip[h] = 1'b0; end
      return;
    end
    l  = (req_addr - BASE) & ~64'h7;
    mp = lane_mapped(l);
    rd = '0;
    if (req_valid && !req_wen && mp)
      for (int b = 0; b < 8; b++) rd[8*b +: 8] = rd_byte(l + 64'(b));
    m_rv = req_valid;
    m_re = req_valid && !mp;
    m_rd = rd;
    nm1 = m_mtime + (tick_en ? 64'd1 : 64'd0);
    nm4 = m_mtime4;
    if (tick_en) begin
      m_ph4++;
      if (m_ph4 == 4) begin m_ph4 = 0; nm4 = nm4 + 64'd1; end
    end
    if (req_valid && req_wen && mp) begin
      for (int b = 0; b < 8; b++) begin
        if (req_wstrb[b]) begin
          a  = l + 64'(b);
          by = req_wdata[8*b +: 8];
          if (a < 64'(4*NH)) begin
            i = int'(a);
            if (i % 4 == 0) m_msip[i/4] = by[0];
          end else if (a >= 64'h4000 && a < 64'h4000 + 64'(8*NH)) begin
            i = int'(a - 64'h4000);
            m_cmp[i/8][8*(i%8) +: 8] = by;
          end else if (a >= 64'hBFF8 && a < 64'hC000) begin
            i = int'(a - 64'hBFF8);
            nm1[8*i +: 8] = by;
            nm4[8*i +: 8] = by;
          end
        end
      end
    end
    m_mtime  = nm1;
    m_mtime4 = nm4;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check_model();
    logic [NH-1:0] em, em4, es;
    for (int h = 0; h < NH; h++) begin
      em[h]  = m_mtime  >= m_cmp[h];
      em4[h] = m_mtime4 >= m_cmp[h];
      es[h]  = m_msip[h];
    end
    check("m_resp_valid", resp_valid, m_rv);
    check("m_resp_err", resp_err, m_re);
    check("m_resp_rdata", resp_rdata, m_rd);
    check("m_mtime", mtime_o, m_mtime);
    check("m_mtime_div4", q_mtime_o, m_mtime4);
    check("m_mtip", 64'(mtip), 64'(em));
    check("m_mtip_div4", 64'(q_mtip), 64'(em4));
    check("m_msip", 64'(msip), 64'(es));
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; tick_en = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [63:0] off, input logic [63:0] d, input logic [7:0] s);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + off; req_wdata = d; req_wstrb = s;
    step();
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [63:0] off);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + off; req_wdata = '0; req_wstrb = '0;
    step();
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wen;
    logic [63:0] off;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [11];
  logic [63:0] offs [12];
  logic [63:0] rise_at;

  initial begin
    tbl[0]  = '{1'b0, 64'h4008, 64'h0, 8'h00, 64'd1000000, 1'b0};
    tbl[1]  = '{1'b0, 64'h4000, 64'h0, 8'h00, 64'd1000000, 1'b0};
    tbl[2]  = '{1'b1, 64'h4000, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 64'h4000, 64'h0, 8'h00, 64'h0000_0000_5566_7788, 1'b0};
    tbl[4]  = '{1'b1, 64'h0004, 64'h1_0000_0000, 8'hF0, 64'h0, 1'b0};
    tbl[5]  = '{1'b0, 64'h0000, 64'h0, 8'h00, 64'h1_0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 64'h4010, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[7]  = '{1'b0, 64'hBFF8, 64'h0, 8'h00, 64'h0, 1'b0};
    tbl[8]  = '{1'b1, 64'h8000, 64'hFFFF, 8'hFF, 64'h0, 1'b1};
    tbl[9]  = '{1'b0, 64'h0008, 64'h0, 8'h00, 64'h0, 1'b1};
    tbl[10] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1};

    offs = '{64'h0, 64'h4, 64'h8, 64'h4000, 64'h4004, 64'h4008, 64'h400C,
             64'h4010, 64'hBFF8, 64'hBFFC, 64'hC000, 64'h3FF8};

    reset = 1'b1; tick_en = 1'b0; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    step();
    step();
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mtime", mtime_o, 64'h0);
    check("rst_mtip", 64'(mtip), 64'h0);
    check("rst_msip", 64'(msip), 64'h0);
    check_model();
    reset = 1'b0;

    // Directed table: one access per cycle, response checked the cycle after
    for (int i = 0; i < 11; i++) begin
      req_valid = 1'b1; req_wen = tbl[i].wen; req_addr = BASE + tbl[i].off;
      req_wdata = tbl[i].wdata; req_wstrb = tbl[i].wstrb;
      step();
      check($sformatf("tbl%0d_valid", i), resp_valid, 1'b1);
      check($sformatf("tbl%0d_rdata", i), resp_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_err", i), resp_err, tbl[i].exp_err);
      check_model();
    end
    req_valid = 1'b0;
    step();
    check("tbl_msip", 64'(msip), 64'h2);
    check("tbl_mtip", 64'(mtip), 64'h0);

    // Prescaler: 40 enabled cycles then 10 frozen
    do_reset();
    tick_en = 1'b1;
    repeat (40) begin step(); check_model(); end
    check("div4_mtime", q_mtime_o, 64'd10);
    check("div1_mtime", mtime_o, 64'd40);
    tick_en = 1'b0;
    repeat (10) begin step(); check_model(); end
    check("div4_frozen", q_mtime_o, 64'd10);

    // mtip[0] rises exactly when mtime reaches 5
    do_reset();
    wr(64'h4000, 64'd5, 8'hFF);
    tick_en = 1'b1;
    rise_at = '1;
    for (int c = 0; c < 12; c++) begin
      step();
      check_model();
      check("mtip1_low", 64'(mtip[1]), 64'h0);
      if (mtip[0] && rise_at == '1) rise_at = mtime_o;
    end
    check("mtip0_rise_at", rise_at, 64'd5);
    check("mtime_past_cmp", mtime_o, 64'd12);

    // Wrap-around and partial write on a tick cycle
    do_reset();
    wr(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    check_model();
    tick_en = 1'b1;
    step(); step();
    check("wrap_zero", mtime_o, 64'h0);
    wr(64'hBFF8, 64'h1234, 8'h0F);
    check("tick_wr_lo", mtime_o, 64'h1234);
    tick_en = 1'b0;
    wr(64'hBFF8, 64'h5_FFFF_FFFF, 8'hFF);
    tick_en = 1'b1;
    wr(64'hBFF8, 64'h1234, 8'h0F);
    check("tick_wr_hi", mtime_o, 64'h6_0000_1234);
    check_model();

    // Unmapped hart, reset over a pending response
    do_reset();
    rd(64'h4000 + 64'(8*NH));
    check("oob_valid", resp_valid, 1'b1);
    check("oob_err", resp_err, 1'b1);
    check("oob_rdata", resp_rdata, 64'h0);
    tick_en = 1'b1;
    repeat (3) step();
    rd(64'hBFF8);
    check("pre_rst_valid", resp_valid, 1'b1);
    check_model();
    reset = 1'b1;
    step();
    check("rst_drop_valid", resp_valid, 1'b0);
    check("rst_mtime0", mtime_o, 64'h0);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 64'h4000;
    step();
    check("rst_same_cycle_valid", resp_valid, 1'b0);
    reset = 1'b0; req_valid = 1'b0; tick_en = 1'b0;
    rd(64'h4000);
    check("post_rst_cmp", resp_rdata, CRST);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      tick_en   = ($urandom_range(0, 7) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_wen   = $urandom_range(0, 1);
      req_addr  = ($urandom_range(0, 9) == 0) ? BASE + 64'($urandom_range(0, 16'hFFFF))
                                              : BASE + offs[$urandom_range(0, 11)];
      req_wdata = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                              : m_mtime + 64'($urandom_range(0, 40));
      req_wstrb = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      step();
      check_model();
    end
    reset = 1'b0; req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
